// File: rtl/pc_sequencer.sv
// Registered program counter with stall, halt/resume and single-level interrupt entry/return.
// Latency: a redirect presented in cycle N appears on pc after the next rising edge; pc_plus_4 is combinational.
// Backpressure: stall freezes pc/epc/in_isr/state; only irq is still latched into the pending flag.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   stall               hold all state this cycle (irq still latched)
//   branch, ext18       taken conditional branch, sign-extended pre-shifted offset
//   jmp, target         absolute jump, target field (word index)
//   jr, rs_data         jump to register value (low two bits forced to zero)
//   halt, resume        enter / leave the HALTED state
//   irq, eret           interrupt request pulse, return from interrupt
//   pc, pc_plus_4       fetch address and link value
//   epc, in_isr, halted saved return address, servicing flag, HALTED indicator
module pc_sequencer #(
   parameter int unsigned       PC_W         = 32,
   parameter int unsigned       TARGET_W     = 26,
   parameter logic [PC_W-1:0]   RESET_VECTOR = '0,
   parameter logic [PC_W-1:0]   EXC_VECTOR   = PC_W'(32'h0000_0080)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                branch,
   input  logic [PC_W-1:0]     ext18,
   input  logic                jmp,
   input  logic [TARGET_W-1:0] target,
   input  logic                jr,
   input  logic [PC_W-1:0]     rs_data,
   input  logic                halt,
   input  logic                resume,
   input  logic                irq,
   input  logic                eret,
   output logic [PC_W-1:0]     pc,
   output logic [PC_W-1:0]     pc_plus_4,
   output logic [PC_W-1:0]     epc,
   output logic                in_isr,
   output logic                halted
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   // Bits of pc_plus_4 kept by an absolute jump (region bits above target+2).
   // Collapses to zero when the target field spans the whole PC.
   localparam logic [PC_W-1:0] JMP_HI_MASK = ~((PC_W'(1) << (TARGET_W + 2)) - PC_W'(1));

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] epc_q, epc_d;
   logic            in_isr_q, in_isr_d;
   logic            irq_pending_q, irq_pending_d;

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] jr_next;
   logic [PC_W-1:0] jmp_next;
   logic [PC_W-1:0] seq_next;
   logic            take_irq;

   assign pc_inc   = pc_q + PC_W'(4);
   assign jr_next  = {rs_data[PC_W-1:2], 2'b00};
   assign jmp_next = (pc_inc & JMP_HI_MASK) | (PC_W'(target) << 2);

   // Candidate next PC when running unstalled and no interrupt/eret applies.
   always_comb begin
      seq_next = pc_inc;
      if (branch) begin
         seq_next = pc_inc + ext18;
      end else if (jr) begin
         seq_next = jr_next;
      end else if (jmp) begin
         seq_next = jmp_next;
      end
   end

   // An irq arriving this very cycle counts as pending; no nesting while in_isr.
   assign take_irq = (irq_pending_q | irq) & ~in_isr_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      epc_d         = epc_q;
      in_isr_d      = in_isr_q;
      irq_pending_d = irq_pending_q | irq;

      if (!stall) begin
         case (state_q)
            ST_RUN: begin
               if (take_irq) begin
                  pc_d          = EXC_VECTOR;
                  epc_d         = seq_next;
                  in_isr_d      = 1'b1;
                  irq_pending_d = 1'b0;
               end else if (eret && in_isr_q) begin
                  pc_d     = epc_q;
                  in_isr_d = 1'b0;
               end else if (halt) begin
                  pc_d    = seq_next;
                  state_d = ST_HALTED;
               end else begin
                  pc_d = seq_next;
               end
            end
            ST_HALTED: begin
               // Interrupt wins over resume; the halted PC becomes the return address.
               if (take_irq) begin
                  pc_d          = EXC_VECTOR;
                  epc_d         = pc_q;
                  in_isr_d      = 1'b1;
                  irq_pending_d = 1'b0;
                  state_d       = ST_RUN;
               end else if (resume) begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_VECTOR;
         epc_q         <= '0;
         in_isr_q      <= 1'b0;
         irq_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         epc_q         <= epc_d;
         in_isr_q      <= in_isr_d;
         irq_pending_q <= irq_pending_d;
      end
   end

   assign pc        = pc_q;
   assign pc_plus_4 = pc_inc;
   assign epc       = epc_q;
   assign in_isr    = in_isr_q;
   assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, branch, jmp, jr, halt, resume, irq, eret;
   logic [31:0] ext18, rs_data;
   logic [25:0] target;
   logic [31:0] pc, pc_plus_4, epc;
   logic        in_isr, halted;

   // Narrow build: 16-bit PC, 12-bit target field.
   logic        rst16_n;
   logic        jmp16;
   logic [11:0] target16;
   logic [15:0] pc16, pc16_plus_4, epc16;
   logic        in_isr16, halted16;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      logic        isr;
      logic        hlt;
      string       tag;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   pc_sequencer u_dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .ext18(ext18),
      .jmp(jmp), .target(target), .jr(jr), .rs_data(rs_data), .halt(halt),
      .resume(resume), .irq(irq), .eret(eret), .pc(pc), .pc_plus_4(pc_plus_4),
      .epc(epc), .in_isr(in_isr), .halted(halted)
   );

   pc_sequencer #(
      .PC_W(16), .TARGET_W(12), .RESET_VECTOR(16'hC000), .EXC_VECTOR(16'h0080)
   ) u_dut16 (
      .clk(clk), .rst_n(rst16_n), .stall(1'b0), .branch(1'b0), .ext18(16'h0),
      .jmp(jmp16), .target(target16), .jr(1'b0), .rs_data(16'h0), .halt(1'b0),
      .resume(1'b0), .irq(1'b0), .eret(1'b0), .pc(pc16), .pc_plus_4(pc16_plus_4),
      .epc(epc16), .in_isr(in_isr16), .halted(halted16)
   );

   task automatic idle();
      stall = 0; branch = 0; jmp = 0; jr = 0; halt = 0; resume = 0; irq = 0; eret = 0;
      ext18 = '0; rs_data = '0; target = '0;
   endtask

   task automatic push(input logic [31:0] p, input logic [31:0] e, input logic i,
                       input logic h, input string tag);
      exp_t x;
      x.pc = p; x.epc = e; x.isr = i; x.hlt = h; x.tag = tag;
      sb_q.push_back(x);
   endtask

   task automatic compare();
      exp_t x;
      logic [31:0] p4;
      if (sb_q.size() == 0) begin
         n_cmp++; n_err++;
         $error("FAIL scoreboard_empty got 0 entries want 1");
         return;
      end
      x  = sb_q.pop_front();
      p4 = x.pc + 32'd4;
      n_cmp++;
      assert (pc === x.pc) else begin
         n_err++; $error("FAIL %s.pc got %h want %h", x.tag, pc, x.pc);
      end
      n_cmp++;
      assert (pc_plus_4 === p4) else begin
         n_err++; $error("FAIL %s.pc_plus_4 got %h want %h", x.tag, pc_plus_4, p4);
      end
      n_cmp++;
      assert (epc === x.epc) else begin
         n_err++; $error("FAIL %s.epc got %h want %h", x.tag, epc, x.epc);
      end
      n_cmp++;
      assert (in_isr === x.isr) else begin
         n_err++; $error("FAIL %s.in_isr got %b want %b", x.tag, in_isr, x.isr);
      end
      n_cmp++;
      assert (halted === x.hlt) else begin
         n_err++; $error("FAIL %s.halted got %b want %b", x.tag, halted, x.hlt);
      end
   endtask

   // Expected state after the next rising edge with the inputs currently driven.
   task automatic cyc(input logic [31:0] p, input logic [31:0] e, input logic i,
                      input logic h, input string tag);
      push(p, e, i, h, tag);
      @(posedge clk);
      #1;
      compare();
   endtask

   // Expected state right now, without a clock edge.
   task automatic now(input logic [31:0] p, input logic [31:0] e, input logic i,
                      input logic h, input string tag);
      push(p, e, i, h, tag);
      #1;
      compare();
   endtask

   task automatic chk16(input logic [15:0] want, input string tag);
      n_cmp++;
      assert (pc16 === want) else begin
         n_err++; $error("FAIL %s got %h want %h", tag, pc16, want);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst_n = 0; rst16_n = 0; jmp16 = 0; target16 = '0;
      repeat (3) @(posedge clk);
      #1;
      now(32'h0, 32'h0, 0, 0, "reset");
      rst_n = 1;
      now(32'h0, 32'h0, 0, 0, "release");
      cyc(32'h4, 32'h0, 0, 0, "seq1");
      cyc(32'h8, 32'h0, 0, 0, "seq2");

      // Interrupt entry, then jr inside the ISR to 0x40, then asynchronous reset.
      irq = 1;
      cyc(32'h80, 32'hC, 1, 0, "irq_entry");
      irq = 0;
      cyc(32'h84, 32'hC, 1, 0, "isr_seq");
      jr = 1; rs_data = 32'h40;
      cyc(32'h40, 32'hC, 1, 0, "isr_jr");
      idle();
      #2 rst_n = 0;
      now(32'h0, 32'h0, 0, 0, "async_reset");
      @(posedge clk);
      #1;
      rst_n = 1;
      now(32'h0, 32'h0, 0, 0, "release2");
      cyc(32'h4, 32'h0, 0, 0, "rseq1");
      cyc(32'h8, 32'h0, 0, 0, "rseq2");

      // Next-PC priority: branch > jr > jmp.
      jr = 1; rs_data = 32'h100;
      cyc(32'h100, 32'h0, 0, 0, "jr_100");
      branch = 1; ext18 = 32'hFFFF_FFF0; jr = 1; rs_data = 32'h203; jmp = 1; target = 26'h40;
      cyc(32'hF4, 32'h0, 0, 0, "prio_branch");
      idle(); jr = 1; rs_data = 32'h203;
      cyc(32'h200, 32'h0, 0, 0, "prio_jr");
      idle(); jmp = 1; target = 26'h40;
      cyc(32'h100, 32'h0, 0, 0, "prio_jmp");
      idle(); jr = 1; rs_data = 32'hA000_0010;
      cyc(32'hA000_0010, 32'h0, 0, 0, "jr_hi");
      idle(); jmp = 1; target = 26'h123;
      cyc(32'hA000_048C, 32'h0, 0, 0, "jmp_keep_hi");
      idle(); jr = 1; rs_data = 32'hFFFF_FFFC;
      cyc(32'hFFFF_FFFC, 32'h0, 0, 0, "jr_top");
      idle();
      cyc(32'h0, 32'h0, 0, 0, "wrap");

      // Stall holds everything; irq during stall is taken on the first free edge.
      jr = 1; rs_data = 32'h20;
      cyc(32'h20, 32'h0, 0, 0, "jr_20");
      idle(); stall = 1; branch = 1; ext18 = 32'h100;
      cyc(32'h20, 32'h0, 0, 0, "stall1");
      irq = 1;
      cyc(32'h20, 32'h0, 0, 0, "stall2_irq");
      irq = 0; halt = 1;
      cyc(32'h20, 32'h0, 0, 0, "stall3_halt");
      idle();
      cyc(32'h80, 32'h24, 1, 0, "irq_after_stall");

      // Second irq inside the ISR stays pending until after eret.
      irq = 1;
      cyc(32'h84, 32'h24, 1, 0, "irq_nested_pend");
      idle(); eret = 1;
      cyc(32'h24, 32'h24, 0, 0, "eret");
      idle();
      cyc(32'h80, 32'h28, 1, 0, "pending_taken");
      eret = 1;
      cyc(32'h28, 32'h28, 0, 0, "eret2");
      cyc(32'h2C, 32'h28, 0, 0, "eret_ignored");

      // Halt / resume.
      idle(); jr = 1; rs_data = 32'h30;
      cyc(32'h30, 32'h28, 0, 0, "jr_30");
      idle(); halt = 1;
      cyc(32'h34, 32'h28, 0, 1, "halt");
      idle(); jmp = 1; target = 26'h10; branch = 1; ext18 = 32'h40; halt = 1; eret = 1;
      for (int k = 0; k < 10; k++) cyc(32'h34, 32'h28, 0, 1, "halted_hold");
      idle(); resume = 1;
      cyc(32'h34, 32'h28, 0, 0, "resume");
      idle();
      cyc(32'h38, 32'h28, 0, 0, "after_resume");

      // Halt again; stall freezes exits; pending irq beats resume.
      jr = 1; rs_data = 32'h30;
      cyc(32'h30, 32'h28, 0, 0, "jr_30b");
      idle(); halt = 1;
      cyc(32'h34, 32'h28, 0, 1, "halt2");
      idle(); stall = 1; irq = 1; resume = 1;
      cyc(32'h34, 32'h28, 0, 1, "halted_stall");
      idle(); resume = 1;
      cyc(32'h80, 32'h34, 1, 0, "halted_irq");
      idle();

      // 16-bit build: jmp keeps pc_plus_4 region bits.
      rst16_n = 1;
      #1;
      chk16(16'hC000, "w16_reset");
      jmp16 = 1; target16 = 12'h123;
      @(posedge clk);
      #1;
      chk16(16'hC48C, "w16_jmp");
      jmp16 = 0;

      n_cmp++;
      assert (sb_q.size() == 0) else begin
         n_err++; $error("FAIL scoreboard_left got %0d want 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit. It owns the PC register and computes the next PC from the sequential, branch, jump and jump-register paths.
- Adds three behaviours the previous combinational next-PC logic lacked: a pipeline stall, a halt/resume state machine, and a single-level interrupt entry/return with an EPC register.
- Sits at the front of the fetch stage. It drives the instruction-memory address and the PC+4 link value to the datapath.

Parameters:
- PC_W, 32, width of the PC and of all address operands.
- TARGET_W, 26, width of the jump target field. Must satisfy TARGET_W+2 <= PC_W.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, interrupt handler entry address.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC this cycle; no state update except latching irq into irq_pending.
- branch  input  1  conditional branch taken.
- ext18  input  PC_W  sign-extended, pre-shifted branch offset.
- jmp  input  1  absolute jump.
- target  input  TARGET_W  jump target field.
- jr  input  1  jump register.
- rs_data  input  PC_W  register value for jr.
- halt  input  1  enter HALTED (syscall/halt instruction retired).
- resume  input  1  leave HALTED.
- irq  input  1  interrupt request pulse.
- eret  input  1  return from interrupt.
- pc  output  PC_W  current PC (fetch address).
- pc_plus_4  output  PC_W  pc+4, combinational.
- epc  output  PC_W  saved return address.
- in_isr  output  1  interrupt being serviced.
- halted  output  1  state == HALTED.

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_VECTOR, epc=0, in_isr=0, irq_pending=0, state=RUN. Release is synchronous to the next edge.
- irq_pending is set on any cycle with irq=1, including during stall or HALTED. It is cleared only when the interrupt is taken.
- Candidate next PC, seq_next, by priority:
  - branch: pc_plus_4+ext18.
  - else jr: {rs_data[PC_W-1:2],2'b00} (low bits forced to zero).
  - else jmp: {pc_plus_4[PC_W-1:TARGET_W+2], target, 2'b00}.
  - else pc_plus_4.
- All arithmetic is modulo 2^PC_W; wrap-around is silent.
- RUN state, stall=0, one update per edge, by priority:
  1. (irq_pending|irq) & !in_isr: pc<=EXC_VECTOR, epc<=seq_next, in_isr<=1, irq_pending<=0.
  2. eret & in_isr: pc<=epc, in_isr<=0.
  3. halt: pc<=seq_next, state<=HALTED.
  4. Otherwise: pc<=seq_next.
- eret with in_isr=0 is ignored and treated as a sequential step.
- An irq arriving while in_isr=1 stays pending and is taken on the first unstalled RUN cycle after eret completes. No nesting.
- RUN state, stall=1: pc, epc, in_isr and state hold. stall has priority over halt, eret and branch.
- HALTED state: pc holds, and branch/jmp/jr/halt/eret are ignored.
  - Exits to RUN on resume, with pc unchanged.
  - Exits to RUN on a pending irq with in_isr=0, with pc<=EXC_VECTOR and epc<=pc (the halted PC).
  - If both are present, irq wins.
  - stall also freezes HALTED exits.
- Latency: a redirect presented in cycle N is visible on pc after edge N+1. pc_plus_4 follows pc combinationally.

Test Plan:
- Reset: hold rst_n=0 mid-run with pc=0x40 -> pc=0x0, epc=0, in_isr=0, halted=0 immediately (asynchronously). Release -> pc steps 0x0, 0x4, 0x8.
- Priority: pc=0x100, branch=1, ext18=0xFFFFFFF0, jr=1, rs_data=0x203, jmp=1 -> next pc=0xF4. Next cycle jr only, rs_data=0x203 -> pc=0x200. Then jmp only, target=0x0000040 -> pc=0x100.
- Stall: pc=0x20, stall=1 for 3 cycles with branch=1 -> pc stays 0x20. Pulse irq during the stall -> taken on the first unstalled edge: pc=0x80, epc=0x24, in_isr=1.
- Interrupt return: in ISR at pc=0x84, a second irq arrives -> stays pending. eret -> pc=0x24, in_isr=0. Next unstalled edge -> pc=0x80, epc=0x28.
- Halt: pc=0x30, halt=1 -> pc=0x34, halted=1. Ten cycles with jmp=1 -> pc stays 0x34. resume -> halted=0, next pc=0x38. Repeat with irq instead of resume -> pc=0x80, epc=0x34.
- Wrap: pc=0xFFFFFFFC, no redirect -> pc=0x0. Parameter PC_W=16, TARGET_W=12 build -> jmp from 0xC000, target=0x123 -> pc=0xC48C.
